// File: rtl/crc32_stream.sv
// crc32_stream: frame-delimited streaming CRC-32 engine with valid/ready beats and a held result
// Configurable width, polynomial, init, reflection, final XOR and residue check.
module crc32_stream #(
   parameter int          DATA_BYTES  = 4,
   parameter logic [31:0] POLY        = 32'h04C11DB7,
   parameter logic [31:0] INIT        = 32'hFFFFFFFF,
   parameter logic [31:0] XOR_OUT     = 32'h00000000,
   parameter bit          REFLECT_IN  = 1'b0,
   parameter bit          REFLECT_OUT = 1'b0,
   parameter logic [31:0] RESIDUE     = 32'h00000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [8*DATA_BYTES-1:0] s_data,
   input  logic [DATA_BYTES-1:0]   s_keep,
   input  logic                    s_sof,
   input  logic                    s_eof,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [31:0]             m_crc,
   output logic [15:0]             m_len,
   output logic                    m_match
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t      state, state_nxt;
   logic [31:0] crc, crc_nxt, crc_fin;
   logic [15:0] cnt, cnt_nxt;
   logic        in_rst, acc;
   assign s_ready = !in_rst && !(m_valid && !m_ready);
   assign acc     = s_valid && s_ready;
   always_comb begin
      state_nxt = acc ? (s_eof ? IDLE : ACTIVE) : state;
   end
   // Lanes are folded in first-byte-first order; on eof only the leading keep run counts.
   always_comb begin
      logic        run;
      logic        fb;
      logic [7:0]  d;
      logic [16:0] n;
      run     = 1'b1;
      fb      = 1'b0;
      d       = 8'h00;
      crc_nxt = (state == IDLE || s_sof) ? INIT : crc;
      n       = {1'b0, (state == IDLE || s_sof) ? 16'h0000 : cnt};
      for (int i = 0; i < DATA_BYTES; i++) begin
         run = run && (!s_eof || s_keep[DATA_BYTES-1-i]);
         d   = s_data[8*(DATA_BYTES-i)-1 -: 8];
         if (run) begin
            for (int j = 0; j < 8; j++) begin
               fb      = crc_nxt[31] ^ (REFLECT_IN ? d[j] : d[7-j]);
               crc_nxt = (crc_nxt << 1) ^ (fb ? POLY : 32'h0);
            end
            n = n + 17'd1;
         end
      end
      cnt_nxt = n[16] ? 16'hFFFF : n[15:0];
      crc_fin = 32'h0;
      for (int k = 0; k < 32; k++) crc_fin[k] = REFLECT_OUT ? crc_nxt[31-k] : crc_nxt[k];
      crc_fin = crc_fin ^ XOR_OUT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         crc     <= INIT;
         cnt     <= 16'h0000;
         in_rst  <= 1'b1;
         m_valid <= 1'b0;
         m_crc   <= 32'h0;
         m_len   <= 16'h0000;
         m_match <= 1'b0;
      end else begin
         in_rst <= 1'b0;
         state  <= state_nxt;
         if (acc) begin
            crc <= s_eof ? INIT : crc_nxt;
            cnt <= s_eof ? 16'h0000 : cnt_nxt;
         end
         if (acc && s_eof) begin
            m_valid <= 1'b1;
            m_crc   <= crc_fin;
            m_len   <= cnt_nxt;
            m_match <= (crc_fin == RESIDUE);
         end else if (m_ready) m_valid <= 1'b0;
      end
   end
endmodule
